// File: rtl/button_toggle_bank.sv
// Debounced push-button bank: per-channel press/release lockout FSMs driving
// toggle, momentary or exclusive one-hot state flags.
//
// state       | meaning
// ------------+---------------------------------------------------
// IDLE        | released, waiting for a synchronized press
// PRESS_LOCK  | press detected, input ignored for the lockout ticks
// HELD        | pressed, waiting for a synchronized release
// REL_LOCK    | release detected, input ignored for the lockout ticks
module button_toggle_bank #(
  parameter int N_CH        = 2,
  parameter int TICK_DIV    = 100000,
  parameter int DEBOUNCE_MS = 200,
  parameter int MODE        = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set,
  input  logic            clear,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] state,
  output logic [N_CH-1:0] press_pulse
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int LW = $clog2(DEBOUNCE_MS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(DEBOUNCE_MS - 1);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_PRESS_LOCK = 2'd1;
  localparam logic [1:0] ST_HELD       = 2'd2;
  localparam logic [1:0] ST_REL_LOCK   = 2'd3;

  logic [N_CH-1:0] sync1_q, sync2_q;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic            tick;

  logic [1:0]      fsm_q  [N_CH];
  logic [1:0]      fsm_d  [N_CH];
  logic [LW-1:0]   lock_q [N_CH];
  logic [LW-1:0]   lock_d [N_CH];

  logic [N_CH-1:0] detect, accept, held_d, low_acc;
  logic [N_CH-1:0] state_q, state_d;
  logic [N_CH-1:0] pulse_q;

  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

  always_comb begin
    detect = '0;
    held_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      fsm_d[i]  = fsm_q[i];
      lock_d[i] = lock_q[i];
      case (fsm_q[i])
        ST_IDLE: begin
          if (sync2_q[i]) begin
            fsm_d[i]  = ST_PRESS_LOCK;
            lock_d[i] = '0;
            detect[i] = 1'b1;
          end
        end
        ST_PRESS_LOCK: begin
          if (tick) begin
            lock_d[i] = lock_q[i] + LW'(1);
            if (lock_q[i] == LOCK_LAST) fsm_d[i] = ST_HELD;
          end
        end
        ST_HELD: begin
          if (!sync2_q[i]) begin
            fsm_d[i]  = ST_REL_LOCK;
            lock_d[i] = '0;
          end
        end
        ST_REL_LOCK: begin
          if (tick) begin
            lock_d[i] = lock_q[i] + LW'(1);
            if (lock_q[i] == LOCK_LAST) fsm_d[i] = ST_IDLE;
          end
        end
        default: fsm_d[i] = ST_IDLE;
      endcase
      held_d[i] = (fsm_d[i] == ST_PRESS_LOCK) || (fsm_d[i] == ST_HELD);
    end
  end

  assign accept  = detect & {N_CH{set}};
  // Isolate the lowest accepted channel for exclusive-mode resolution.
  assign low_acc = accept & (~accept + N_CH'(1));

  always_comb begin
    state_d = state_q;
    if (MODE == 0) begin
      state_d = state_q ^ accept;
    end else if (MODE == 1) begin
      state_d = set ? held_d : '0;
    end else if (low_acc != '0) begin
      state_d = ((state_q & low_acc) != '0) ? '0 : low_acc;
    end
    if (clear) state_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      tick_cnt_q <= '0;
      state_q    <= '0;
      pulse_q    <= '0;
      for (int i = 0; i < N_CH; i++) begin
        fsm_q[i]  <= ST_IDLE;
        lock_q[i] <= '0;
      end
    end else begin
      sync1_q    <= btn;
      sync2_q    <= sync1_q;
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      pulse_q    <= accept;
      for (int i = 0; i < N_CH; i++) begin
        fsm_q[i]  <= fsm_d[i];
        lock_q[i] <= lock_d[i];
      end
    end
  end

  assign state       = state_q;
  assign press_pulse = pulse_q;

endmodule

// File: tb/tb_button_toggle_bank.sv
// Bench for button_toggle_bank: three instances (toggle, momentary, exclusive)
// share one stimulus and are compared against a tick-counting press model.
module tb_button_toggle_bank;

  localparam int N  = 2;
  localparam int TD = 4;
  localparam int DM = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         set_in = 1'b1;
  logic         clear_in = 1'b0;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] st0, st1, st2, pp0, pp1, pp2;
  logic [6*N-1:0] obs;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  button_toggle_bank #(.N_CH(N), .TICK_DIV(TD), .DEBOUNCE_MS(DM), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .set(set_in), .clear(clear_in), .btn(btn_in),
    .state(st0), .press_pulse(pp0));
  button_toggle_bank #(.N_CH(N), .TICK_DIV(TD), .DEBOUNCE_MS(DM), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .set(set_in), .clear(clear_in), .btn(btn_in),
    .state(st1), .press_pulse(pp1));
  button_toggle_bank #(.N_CH(N), .TICK_DIV(TD), .DEBOUNCE_MS(DM), .MODE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .set(set_in), .clear(clear_in), .btn(btn_in),
    .state(st2), .press_pulse(pp2));

  assign obs = {st0, pp0, st1, pp1, st2, pp2};

  // Reference: each channel remembers the last accepted level and how many
  // ticks of lockout remain; edges since reset give the tick phase.
  logic [N-1:0] m_s1, m_s, m_pressed, m_pulse;
  logic [N-1:0] m_state [3];
  int           m_busy  [N];
  int           m_edges;

  task automatic model_reset();
    m_s1 = '0; m_s = '0; m_pressed = '0; m_pulse = '0; m_edges = 0;
    for (int k = 0; k < 3; k++) m_state[k] = '0;
    for (int i = 0; i < N; i++) m_busy[i] = 0;
  endtask

  task automatic model_update();
    logic [N-1:0] acc;
    int win;
    bit tk;
    tk  = (m_edges % TD) == TD - 1;
    acc = '0;
    win = -1;
    for (int i = 0; i < N; i++) begin
      if (m_busy[i] == 0) begin
        if (!m_pressed[i] && m_s[i]) begin
          m_pressed[i] = 1'b1; m_busy[i] = DM; acc[i] = set_in;
        end else if (m_pressed[i] && !m_s[i]) begin
          m_pressed[i] = 1'b0; m_busy[i] = DM;
        end
      end else if (tk) begin
        m_busy[i] = m_busy[i] - 1;
      end
    end
    m_pulse    = acc;
    m_state[0] = m_state[0] ^ acc;
    m_state[1] = set_in ? m_pressed : '0;
    for (int i = N - 1; i >= 0; i--) if (acc[i]) win = i;
    if (win >= 0) m_state[2] = m_state[2][win] ? '0 : (N'(1) << win);
    if (clear_in) for (int k = 0; k < 3; k++) m_state[k] = '0;
    m_s     = m_s1;
    m_s1    = btn_in;
    m_edges = m_edges + 1;
  endtask

  function automatic logic [6*N-1:0] exp_vec();
    return {m_state[0], m_pulse, m_state[1], m_pulse, m_state[2], m_pulse};
  endfunction

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_update();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_in = '0; set_in = 1'b1; clear_in = 1'b0;
    model_reset();
    repeat (3) step();
    n_checks++;
    if (obs !== '0) begin
      n_errors++; $display("FAIL reset_outputs got %h exp %h", obs, {6*N{1'b0}});
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if (obs !== exp_vec()) begin
      n_errors++; $display("FAIL reset_release got %h exp %h", obs, exp_vec());
    end
  endtask

  task automatic test_clean_press();
    logic [N-1:0] exp_pp;
    btn_in = 2'b01;
    for (int c = 1; c <= 4; c++) begin
      step();
      exp_pp = (c == 3) ? 2'b01 : 2'b00;
      n_checks++;
      if (pp0 !== exp_pp) begin
        n_errors++; $display("FAIL clean_pulse cyc %0d got %b exp %b", c, pp0, exp_pp);
      end
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++; $display("FAIL clean_model cyc %0d got %h exp %h", c, obs, exp_vec());
      end
    end
    n_checks++;
    if (st0 !== 2'b01) begin
      n_errors++; $display("FAIL clean_state1 got %b exp 01", st0);
    end
    btn_in = 2'b00;
    for (int c = 0; c < 40; c++) begin
      step(); n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++; $display("FAIL clean_release cyc %0d got %h exp %h", c, obs, exp_vec());
      end
    end
    btn_in = 2'b01;
    repeat (3) step();
    n_checks++;
    if (st0 !== 2'b00 || pp0 !== 2'b01) begin
      n_errors++; $display("FAIL clean_second got st=%b pp=%b exp st=00 pp=01", st0, pp0);
    end
    btn_in = 2'b00;
    for (int c = 0; c < 40; c++) begin
      step(); n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++; $display("FAIL clean_idle cyc %0d got %h exp %h", c, obs, exp_vec());
      end
    end
  endtask

  task automatic test_bounce();
    int pulses;
    pulses = 0;
    for (int c = 0; c < 35; c++) begin
      btn_in[0] = (c >= 10) ? 1'b1 : (((c / 2) % 2) == 0);
      step();
      pulses += int'(pp0[0]);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++; $display("FAIL bounce_press cyc %0d got %h exp %h", c, obs, exp_vec());
      end
    end
    n_checks++;
    if (pulses != 1 || st0 !== 2'b01) begin
      n_errors++; $display("FAIL bounce_press_count got pulses=%0d st=%b exp pulses=1 st=01", pulses, st0);
    end
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      btn_in[0] = (c >= 10) ? 1'b0 : (((c / 2) % 2) == 1);
      step();
      pulses += int'(pp0[0]);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++; $display("FAIL bounce_release cyc %0d got %h exp %h", c, obs, exp_vec());
      end
    end
    n_checks++;
    if (pulses != 0 || st0 !== 2'b01) begin
      n_errors++; $display("FAIL bounce_release_count got pulses=%0d st=%b exp pulses=0 st=01", pulses, st0);
    end
  endtask

  task automatic test_exclusive();
    clear_in = 1'b1; step(); clear_in = 1'b0;
    btn_in = 2'b10;
    repeat (3) step();
    n_checks++;
    if (st2 !== 2'b10 || pp2 !== 2'b10) begin
      n_errors++; $display("FAIL excl_ch1 got st=%b pp=%b exp st=10 pp=10", st2, pp2);
    end
    btn_in = 2'b00;
    for (int c = 0; c < 40; c++) begin
      step(); n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++; $display("FAIL excl_release cyc %0d got %h exp %h", c, obs, exp_vec());
      end
    end
    btn_in = 2'b11;
    repeat (3) step();
    n_checks++;
    if (st2 !== 2'b01 || pp2 !== 2'b11) begin
      n_errors++; $display("FAIL excl_both got st=%b pp=%b exp st=01 pp=11", st2, pp2);
    end
    btn_in = 2'b00;
    for (int c = 0; c < 40; c++) begin
      step(); n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++; $display("FAIL excl_idle cyc %0d got %h exp %h", c, obs, exp_vec());
      end
    end
  endtask

  task automatic test_set_gating();
    int pulses;
    pulses = 0;
    clear_in = 1'b1; step(); clear_in = 1'b0;
    set_in = 1'b0; btn_in = 2'b01;
    for (int c = 0; c < 30; c++) begin
      if (c == 15) set_in = 1'b1;
      step();
      pulses += int'(pp0[0]);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++; $display("FAIL gate_hold cyc %0d got %h exp %h", c, obs, exp_vec());
      end
    end
    n_checks++;
    if (pulses != 0 || st0 !== 2'b00) begin
      n_errors++; $display("FAIL gate_no_press got pulses=%0d st=%b exp pulses=0 st=00", pulses, st0);
    end
    btn_in = 2'b00;
    repeat (40) step();
    btn_in = 2'b01;
    repeat (3) step();
    n_checks++;
    if (st0 !== 2'b01 || pp0 !== 2'b01) begin
      n_errors++; $display("FAIL gate_next_press got st=%b pp=%b exp st=01 pp=01", st0, pp0);
    end
    btn_in = 2'b00;
    for (int c = 0; c < 40; c++) begin
      step(); n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++; $display("FAIL gate_idle cyc %0d got %h exp %h", c, obs, exp_vec());
      end
    end
  endtask

  task automatic test_clear_collision();
    clear_in = 1'b1; step(); clear_in = 1'b0;
    btn_in = 2'b01;
    step(); step();
    clear_in = 1'b1;
    step();
    clear_in = 1'b0;
    n_checks++;
    if (st0 !== 2'b00 || pp0 !== 2'b01) begin
      n_errors++; $display("FAIL clear_collide got st=%b pp=%b exp st=00 pp=01", st0, pp0);
    end
    n_checks++;
    if (obs !== exp_vec()) begin
      n_errors++; $display("FAIL clear_model got %h exp %h", obs, exp_vec());
    end
    btn_in = 2'b00;
    repeat (40) step();
  endtask

  task automatic test_reset_midpress();
    btn_in = 2'b01;
    repeat (3) step();
    n_checks++;
    if (st0 !== 2'b01) begin
      n_errors++; $display("FAIL midrst_pre got st=%b exp 01", st0);
    end
    repeat (2) step();
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (st0 !== 2'b00 || pp0 !== 2'b00) begin
      n_errors++; $display("FAIL midrst_async got st=%b pp=%b exp st=00 pp=00", st0, pp0);
    end
    step();
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step(); n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++; $display("FAIL midrst_model cyc %0d got %h exp %h", c, obs, exp_vec());
      end
    end
    n_checks++;
    if (st0 !== 2'b01 || pp0 !== 2'b01) begin
      n_errors++; $display("FAIL midrst_repress got st=%b pp=%b exp st=01 pp=01", st0, pp0);
    end
    btn_in = 2'b00;
    repeat (40) step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) btn_in[$urandom_range(0, N - 1)] ^= 1'b1;
      set_in   = ($urandom_range(0, 9) != 0);
      clear_in = ($urandom_range(0, 39) == 0);
      step(); n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++; $display("FAIL random cyc %0d got %h exp %h", c, obs, exp_vec());
      end
    end
    set_in = 1'b1; clear_in = 1'b0; btn_in = '0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_exclusive();
    test_set_gating();
    test_clear_collision();
    test_reset_midpress();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
